// File: rtl/bmem_arb_pkg.sv
// Shared types and constants for the banked-memory arbiter.
// Holds the FSM/client enums, the default geometry and the line-offset helper.
package bmem_arb_pkg;

    localparam int unsigned BEAT_W_DEF    = 64;
    localparam int unsigned BURST_LEN_DEF = 4;
    localparam int unsigned LINE_W_DEF    = BEAT_W_DEF * BURST_LEN_DEF;
    // Byte-offset bits inside a 32-byte cache line
    localparam int unsigned LINE_OFF_BITS = 5;

    typedef enum logic {
        IDLE     = 1'b0,
        WR_BURST = 1'b1
    } arb_state_e;

    typedef enum logic {
        CLIENT_I = 1'b0,
        CLIENT_D = 1'b1
    } client_e;

    // Strip the in-line byte offset from an address
    function automatic logic [31:0] line_addr(input logic [31:0] addr);
        return {addr[31:LINE_OFF_BITS], {LINE_OFF_BITS{1'b0}}};
    endfunction

endpackage

// File: rtl/bmem_line_assembler.sv
// Per-client read tracker: remembers one outstanding line address, gathers the
// returning beats into a full line and pulses resp_o after the final beat.
module bmem_line_assembler
    import bmem_arb_pkg::*;
#(
    parameter  int unsigned BEAT_W    = BEAT_W_DEF,
    parameter  int unsigned BURST_LEN = BURST_LEN_DEF,
    localparam int unsigned LINE_W    = BEAT_W * BURST_LEN
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              issue_i,
    input  logic [31:0]       issue_addr_i,
    input  logic [31:0]       bmem_raddr_i,
    input  logic [BEAT_W-1:0] bmem_rdata_i,
    input  logic              bmem_rvalid_i,
    output logic              busy_o,
    output logic [31:0]       addr_o,
    output logic [LINE_W-1:0] line_o,
    output logic              resp_o
);

    localparam int unsigned CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    logic              vld_q,  vld_d;
    logic [31:0]       addr_q, addr_d;
    logic [CNT_W-1:0]  cnt_q,  cnt_d;
    logic [LINE_W-1:0] line_q, line_d;
    logic              resp_q, resp_d;
    logic              beat_hit;

    assign beat_hit = vld_q && bmem_rvalid_i && (bmem_raddr_i == addr_q);

    // Next-state: open an entry on issue, store matching beats, close on the last one
    always_comb begin
        vld_d  = vld_q;
        addr_d = addr_q;
        cnt_d  = cnt_q;
        line_d = line_q;
        resp_d = 1'b0;
        if (issue_i) begin
            vld_d  = 1'b1;
            addr_d = issue_addr_i;
            cnt_d  = '0;
        end else if (beat_hit) begin
            line_d[cnt_q*BEAT_W +: BEAT_W] = bmem_rdata_i;
            if (cnt_q == CNT_W'(BURST_LEN - 1)) begin
                vld_d  = 1'b0;
                cnt_d  = '0;
                resp_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Entry, beat counter and line registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q  <= 1'b0;
            addr_q <= '0;
            cnt_q  <= '0;
            line_q <= '0;
            resp_q <= 1'b0;
        end else begin
            vld_q  <= vld_d;
            addr_q <= addr_d;
            cnt_q  <= cnt_d;
            line_q <= line_d;
            resp_q <= resp_d;
        end
    end

    assign busy_o = vld_q;
    assign addr_o = addr_q;
    assign line_o = line_q;
    assign resp_o = resp_q;

endmodule

// File: rtl/bmem_arbiter.sv
// Shares one banked-memory port between an I-cache and a D-cache client.
// Reads issue in a single IDLE cycle and may overlap across clients; D-side
// writes stream BURST_LEN beats in WR_BURST. Optional perf counters are
// compiled in with BMEM_ARB_PERF_EN.
module bmem_arbiter
    import bmem_arb_pkg::*;
#(
    parameter  int unsigned BEAT_W    = BEAT_W_DEF,
    parameter  int unsigned BURST_LEN = BURST_LEN_DEF,
    localparam int unsigned LINE_W    = BEAT_W * BURST_LEN
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       i_addr,
    input  logic              i_read,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic [31:0]       d_addr,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic [31:0]       bmem_addr,
    output logic              bmem_read,
    output logic              bmem_write,
    output logic [BEAT_W-1:0] bmem_wdata,
    input  logic              bmem_ready,
    input  logic [31:0]       bmem_raddr,
    input  logic [BEAT_W-1:0] bmem_rdata,
    input  logic              bmem_rvalid
`ifdef BMEM_ARB_PERF_EN
   ,output logic [31:0]       perf_i_grants,
    output logic [31:0]       perf_d_grants,
    output logic [31:0]       perf_conflict_cycles
`endif
);

    localparam int unsigned CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    arb_state_e       state_q, state_d;
    client_e          last_q, last_d;
    logic [CNT_W-1:0] wr_beat_q, wr_beat_d;
    logic             d_wr_resp_q, d_wr_resp_d;

    logic              i_busy, d_busy;
    logic [31:0]       i_out_addr, d_out_addr;
    logic [LINE_W-1:0] i_line, d_line;
    logic              i_rd_resp, d_rd_resp;

    logic i_pend, d_pend, i_ok, d_rd_ok, d_wr_ok, d_ok;
    logic grant_i, grant_d_rd, grant_d_wr;

    assign d_resp  = d_rd_resp | d_wr_resp_q;
    assign i_resp  = i_rd_resp;
    assign i_rdata = i_line;
    assign d_rdata = d_line;

    // A request is new work only if not already in flight or being answered;
    // the resp cycle still sees it held high, so it is masked there.
    assign i_pend  = rst_n && i_read && !i_busy && !i_rd_resp;
    assign d_pend  = rst_n && (d_read || d_write) && !d_busy && !d_resp
                     && (state_q == IDLE);
    assign i_ok    = i_pend && (state_q == IDLE) && bmem_ready
                     && !(d_busy && (d_out_addr == line_addr(i_addr)));
    assign d_rd_ok = d_pend && d_read && bmem_ready
                     && !(i_busy && (i_out_addr == line_addr(d_addr)));
    assign d_wr_ok = d_pend && d_write && !i_busy;
    assign d_ok    = d_rd_ok || d_wr_ok;

    // Arbitration, write-burst sequencing and memory-port drive
    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        wr_beat_d   = wr_beat_q;
        d_wr_resp_d = 1'b0;
        grant_i     = 1'b0;
        grant_d_rd  = 1'b0;
        grant_d_wr  = 1'b0;
        bmem_read   = 1'b0;
        bmem_write  = 1'b0;
        bmem_addr   = '0;
        bmem_wdata  = '0;
        case (state_q)
            IDLE: begin
                if (i_ok && (!d_ok || last_q == CLIENT_D)) begin
                    grant_i   = 1'b1;
                    bmem_read = 1'b1;
                    bmem_addr = line_addr(i_addr);
                    last_d    = CLIENT_I;
                end else if (d_rd_ok) begin
                    grant_d_rd = 1'b1;
                    bmem_read  = 1'b1;
                    bmem_addr  = line_addr(d_addr);
                    last_d     = CLIENT_D;
                end else if (d_wr_ok) begin
                    grant_d_wr = 1'b1;
                    state_d    = WR_BURST;
                    wr_beat_d  = '0;
                    last_d     = CLIENT_D;
                end
            end
            WR_BURST: begin
                bmem_write = 1'b1;
                bmem_addr  = line_addr(d_addr);
                bmem_wdata = d_wdata[wr_beat_q*BEAT_W +: BEAT_W];
                if (bmem_ready) begin
                    if (wr_beat_q == CNT_W'(BURST_LEN - 1)) begin
                        state_d     = IDLE;
                        wr_beat_d   = '0;
                        d_wr_resp_d = 1'b1;
                    end else begin
                        wr_beat_d = wr_beat_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state, round-robin history and write-side registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            last_q      <= CLIENT_I;
            wr_beat_q   <= '0;
            d_wr_resp_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            wr_beat_q   <= wr_beat_d;
            d_wr_resp_q <= d_wr_resp_d;
        end
    end

    bmem_line_assembler #(
        .BEAT_W   (BEAT_W),
        .BURST_LEN(BURST_LEN)
    ) u_i_asm (
        .clk          (clk),
        .rst_n        (rst_n),
        .issue_i      (grant_i),
        .issue_addr_i (line_addr(i_addr)),
        .bmem_raddr_i (bmem_raddr),
        .bmem_rdata_i (bmem_rdata),
        .bmem_rvalid_i(bmem_rvalid),
        .busy_o       (i_busy),
        .addr_o       (i_out_addr),
        .line_o       (i_line),
        .resp_o       (i_rd_resp)
    );

    bmem_line_assembler #(
        .BEAT_W   (BEAT_W),
        .BURST_LEN(BURST_LEN)
    ) u_d_asm (
        .clk          (clk),
        .rst_n        (rst_n),
        .issue_i      (grant_d_rd),
        .issue_addr_i (line_addr(d_addr)),
        .bmem_raddr_i (bmem_raddr),
        .bmem_rdata_i (bmem_rdata),
        .bmem_rvalid_i(bmem_rvalid),
        .busy_o       (d_busy),
        .addr_o       (d_out_addr),
        .line_o       (d_line),
        .resp_o       (d_rd_resp)
    );

`ifdef BMEM_ARB_PERF_EN
    logic [31:0] perf_i_q, perf_d_q, perf_conf_q;
    logic        blocked;

    assign blocked = (i_pend && !grant_i) || (d_pend && !(grant_d_rd || grant_d_wr));

    // Saturating grant and blocked-request counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_i_q    <= '0;
            perf_d_q    <= '0;
            perf_conf_q <= '0;
        end else begin
            if (grant_i && perf_i_q != '1)
                perf_i_q <= perf_i_q + 32'd1;
            if ((grant_d_rd || grant_d_wr) && perf_d_q != '1)
                perf_d_q <= perf_d_q + 32'd1;
            if (blocked && perf_conf_q != '1)
                perf_conf_q <= perf_conf_q + 32'd1;
        end
    end

    assign perf_i_grants        = perf_i_q;
    assign perf_d_grants        = perf_d_q;
    assign perf_conflict_cycles = perf_conf_q;
`endif

endmodule

// File: tb/tb_bmem_arbiter.sv
// Directed self-checking bench for bmem_arbiter: single read, overlapping
// reads, stalled write burst, same-line conflict and mid-operation reset.
module tb_bmem_arbiter;

    localparam int unsigned BEAT_W = 64;
    localparam int unsigned LINE_W = 256;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [31:0]       i_addr;
    logic              i_read;
    logic [LINE_W-1:0] i_rdata;
    logic              i_resp;
    logic [31:0]       d_addr;
    logic              d_read;
    logic              d_write;
    logic [LINE_W-1:0] d_wdata;
    logic [LINE_W-1:0] d_rdata;
    logic              d_resp;
    logic [31:0]       bmem_addr;
    logic              bmem_read;
    logic              bmem_write;
    logic [BEAT_W-1:0] bmem_wdata;
    logic              bmem_ready;
    logic [31:0]       bmem_raddr;
    logic [BEAT_W-1:0] bmem_rdata;
    logic              bmem_rvalid;
`ifdef BMEM_ARB_PERF_EN
    logic [31:0]       perf_i_grants, perf_d_grants, perf_conflict_cycles;
`endif

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    int unsigned acc_cnt = 0;
    int unsigned acc_before;

    bmem_arbiter #(.BEAT_W(64), .BURST_LEN(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_addr     (i_addr),
        .i_read     (i_read),
        .i_rdata    (i_rdata),
        .i_resp     (i_resp),
        .d_addr     (d_addr),
        .d_read     (d_read),
        .d_write    (d_write),
        .d_wdata    (d_wdata),
        .d_rdata    (d_rdata),
        .d_resp     (d_resp),
        .bmem_addr  (bmem_addr),
        .bmem_read  (bmem_read),
        .bmem_write (bmem_write),
        .bmem_wdata (bmem_wdata),
        .bmem_ready (bmem_ready),
        .bmem_raddr (bmem_raddr),
        .bmem_rdata (bmem_rdata),
        .bmem_rvalid(bmem_rvalid)
`ifdef BMEM_ARB_PERF_EN
       ,.perf_i_grants       (perf_i_grants),
        .perf_d_grants       (perf_d_grants),
        .perf_conflict_cycles(perf_conflict_cycles)
`endif
    );

    always #5 clk = ~clk;

    // Count write beats actually accepted by memory
    always @(posedge clk) begin
        if (rst_n && bmem_write && bmem_ready)
            acc_cnt++;
    end

    task automatic check(input string tag, input logic [LINE_W-1:0] obs,
                         input logic [LINE_W-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [LINE_W-1:0] mkline(input logic [63:0] base);
        return {base + 64'd3, base + 64'd2, base + 64'd1, base};
    endfunction

    // Memory returns one burst on consecutive cycles, beat k = base+k
    task automatic burst(input logic [31:0] addr, input logic [63:0] base);
        for (int k = 0; k < 4; k++) begin
            bmem_rvalid = 1'b1;
            bmem_raddr  = addr;
            bmem_rdata  = base + 64'(k);
            tick();
        end
        bmem_rvalid = 1'b0;
        bmem_raddr  = '0;
        bmem_rdata  = '0;
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        rst_n = 1'b0;
        i_addr = 32'h1000; i_read = 1'b1;
        d_addr = '0; d_read = 1'b0; d_write = 1'b0; d_wdata = '0;
        bmem_ready = 1'b1; bmem_raddr = '0; bmem_rdata = '0; bmem_rvalid = 1'b0;

        // Outputs held low in reset even with a request present
        tick(); #1;
        check("rst_bmem_read",  256'(bmem_read),  256'd0);
        check("rst_bmem_addr",  256'(bmem_addr),  256'd0);
        check("rst_bmem_write", 256'(bmem_write), 256'd0);
        check("rst_i_resp",     256'(i_resp),     256'd0);
        check("rst_d_resp",     256'(d_resp),     256'd0);
        check("rst_i_rdata",    i_rdata,          256'd0);
        i_read = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        // Single I fetch
        i_addr = 32'h0000_1000; i_read = 1'b1; #1;
        check("s1_issue_read", 256'(bmem_read), 256'd1);
        check("s1_issue_addr", 256'(bmem_addr), 256'h1000);
        tick();
        check("s1_no_reissue", 256'(bmem_read), 256'd0);
        check("s1_no_early_resp", 256'(i_resp), 256'd0);
        burst(32'h1000, 64'hA0A0_0000_0000_0000);
        check("s1_i_resp",  256'(i_resp), 256'd1);
        check("s1_i_rdata", i_rdata, mkline(64'hA0A0_0000_0000_0000));
        i_read = 1'b0;
        tick();
        check("s1_resp_pulse_end", 256'(i_resp), 256'd0);

        // Simultaneous reads after reset: D first, I next, I returns first
        reset_dut();
        i_addr = 32'h1000; i_read = 1'b1;
        d_addr = 32'h2000; d_read = 1'b1; #1;
        check("s2_first_read", 256'(bmem_read), 256'd1);
        check("s2_first_addr", 256'(bmem_addr), 256'h2000);
        tick();
        check("s2_second_read", 256'(bmem_read), 256'd1);
        check("s2_second_addr", 256'(bmem_addr), 256'h1000);
        tick();
        check("s2_idle", 256'(bmem_read), 256'd0);
        burst(32'h1000, 64'hB0B0_0000_0000_0010);
        check("s2_i_resp", 256'(i_resp), 256'd1);
        check("s2_d_not_yet", 256'(d_resp), 256'd0);
        check("s2_i_rdata", i_rdata, mkline(64'hB0B0_0000_0000_0010));
        i_read = 1'b0;
        burst(32'h2000, 64'hC0C0_0000_0000_0020);
        check("s2_d_resp", 256'(d_resp), 256'd1);
        check("s2_i_quiet", 256'(i_resp), 256'd0);
        check("s2_d_rdata", d_rdata, mkline(64'hC0C0_0000_0000_0020));
        check("s2_i_rdata_kept", i_rdata, mkline(64'hB0B0_0000_0000_0010));
        d_read = 1'b0;
        tick();
`ifdef BMEM_ARB_PERF_EN
        check("perf_i_grants", 256'(perf_i_grants), 256'd1);
        check("perf_d_grants", 256'(perf_d_grants), 256'd1);
        check("perf_conflict", 256'(perf_conflict_cycles), 256'd1);
`endif

        // Write burst with memory stall on beat 2
        d_addr = 32'h3000;
        d_wdata = mkline(64'h3333_0000_0000_0000);
        d_write = 1'b1; #1;
        acc_before = acc_cnt;
        check("s3_grant_no_write", 256'(bmem_write), 256'd0);
        tick();
        check("s3_b0_write", 256'(bmem_write), 256'd1);
        check("s3_b0_addr",  256'(bmem_addr),  256'h3000);
        check("s3_b0_data",  256'(bmem_wdata), 256'h3333_0000_0000_0000);
        tick();
        check("s3_b1_data",  256'(bmem_wdata), 256'h3333_0000_0000_0001);
        tick();
        bmem_ready = 1'b0; #1;
        check("s3_b2_stall0", 256'(bmem_wdata), 256'h3333_0000_0000_0002);
        tick();
        check("s3_b2_stall1", 256'(bmem_wdata), 256'h3333_0000_0000_0002);
        check("s3_b2_stall1_wr", 256'(bmem_write), 256'd1);
        tick();
        check("s3_b2_stall2", 256'(bmem_wdata), 256'h3333_0000_0000_0002);
        tick();
        bmem_ready = 1'b1; #1;
        check("s3_b2_release", 256'(bmem_wdata), 256'h3333_0000_0000_0002);
        tick();
        check("s3_b3_data", 256'(bmem_wdata), 256'h3333_0000_0000_0003);
        check("s3_no_early_resp", 256'(d_resp), 256'd0);
        tick();
        check("s3_d_resp", 256'(d_resp), 256'd1);
        check("s3_write_done", 256'(bmem_write), 256'd0);
        check("s3_beats_accepted", 256'(acc_cnt - acc_before), 256'd4);
        d_write = 1'b0;
        tick();
        check("s3_resp_pulse_end", 256'(d_resp), 256'd0);
        check("s3_no_extra_beats", 256'(acc_cnt - acc_before), 256'd4);

        // Same line requested by both clients
        i_addr = 32'h4000; i_read = 1'b1;
        d_addr = 32'h4000; d_read = 1'b1; #1;
        check("s4_first_read", 256'(bmem_read), 256'd1);
        check("s4_first_addr", 256'(bmem_addr), 256'h4000);
        tick();
        check("s4_withheld0", 256'(bmem_read), 256'd0);
        tick();
        check("s4_withheld1", 256'(bmem_read), 256'd0);
        burst(32'h4000, 64'hE0E0_0000_0000_0040);
        check("s4_i_resp", 256'(i_resp), 256'd1);
        check("s4_d_quiet", 256'(d_resp), 256'd0);
        check("s4_i_rdata", i_rdata, mkline(64'hE0E0_0000_0000_0040));
        check("s4_b2b_read", 256'(bmem_read), 256'd1);
        check("s4_b2b_addr", 256'(bmem_addr), 256'h4000);
        i_read = 1'b0;
        tick();
        check("s4_single_second", 256'(bmem_read), 256'd0);
        burst(32'h4000, 64'hF0F0_0000_0000_0050);
        check("s4_d_resp", 256'(d_resp), 256'd1);
        check("s4_i_quiet", 256'(i_resp), 256'd0);
        check("s4_d_rdata", d_rdata, mkline(64'hF0F0_0000_0000_0050));
        check("s4_i_rdata_kept", i_rdata, mkline(64'hE0E0_0000_0000_0040));
        d_read = 1'b0;
        tick();

        // Reset in the middle of a write burst
        d_addr = 32'h6000;
        d_wdata = mkline(64'h6666_0000_0000_0000);
        d_write = 1'b1;
        tick();
        tick();
        tick();
        check("s5_b2_before_rst", 256'(bmem_wdata), 256'h6666_0000_0000_0002);
        rst_n = 1'b0; #1;
        check("s5_rst_write", 256'(bmem_write), 256'd0);
        check("s5_rst_wdata", 256'(bmem_wdata), 256'd0);
        tick();
        check("s5_rst_no_resp", 256'(d_resp), 256'd0);
        d_write = 1'b0;
        rst_n = 1'b1;
        tick();
        check("s5_post_no_resp0", 256'(d_resp), 256'd0);
        tick();
        check("s5_post_no_resp1", 256'(d_resp), 256'd0);
        check("s5_post_no_write", 256'(bmem_write), 256'd0);

        // Read abandoned by reset; its late burst must be dropped
        i_addr = 32'h5000; i_read = 1'b1; #1;
        check("s5_pre_rst_read", 256'(bmem_read), 256'd1);
        tick();
        rst_n = 1'b0; i_read = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        burst(32'h5000, 64'h5555_0000_0000_0000);
        check("s5_stray_no_i_resp", 256'(i_resp), 256'd0);
        check("s5_stray_no_d_resp", 256'(d_resp), 256'd0);
        check("s5_stray_rdata", i_rdata, 256'd0);
        tick();
        check("s5_stray_still_quiet", 256'(i_resp), 256'd0);

        // Fresh read with unaligned address after the stray burst
        i_addr = 32'h0000_7004; i_read = 1'b1; #1;
        check("s6_masked_addr", 256'(bmem_addr), 256'h7000);
        tick();
        burst(32'h7000, 64'h7777_0000_0000_0070);
        check("s6_i_resp", 256'(i_resp), 256'd1);
        check("s6_i_rdata", i_rdata, mkline(64'h7777_0000_0000_0070));
        i_read = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
